// File: rtl/ctrl_pkg.sv
// Shared encodings for the MiniSRC control unit: opcodes, ALU codes, FSM states, IR fields.
package ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_PASSA = 4'd0;
    localparam logic [3:0] ALU_ADD   = 4'd1;
    localparam logic [3:0] ALU_SUB   = 4'd2;
    localparam logic [3:0] ALU_AND   = 4'd3;
    localparam logic [3:0] ALU_OR    = 4'd4;
    localparam logic [3:0] ALU_ROR   = 4'd5;
    localparam logic [3:0] ALU_ROL   = 4'd6;
    localparam logic [3:0] ALU_SHR   = 4'd7;
    localparam logic [3:0] ALU_SHRA  = 4'd8;
    localparam logic [3:0] ALU_SHL   = 4'd9;
    localparam logic [3:0] ALU_MUL   = 4'd10;
    localparam logic [3:0] ALU_DIV   = 4'd11;
    localparam logic [3:0] ALU_NEG   = 4'd12;
    localparam logic [3:0] ALU_NOT   = 4'd13;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;
    localparam int C2_HI  = 20;
    localparam int C2_LO  = 19;
    localparam int IMM_HI = 18;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_WRITE  = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    // Instruction class selects the path through the state sequence.
    typedef enum logic [3:0] {
        CLS_ALU, CLS_LD, CLS_ST, CLS_MULDIV, CLS_BR, CLS_JR, CLS_MF, CLS_NOP, CLS_HALT
    } class_t;

    typedef struct packed {
        logic [3:0] alu_ctrl;
        logic       use_imm;
        class_t     cls;
        logic       legal;
    } decode_t;

    function automatic logic [31:0] sign_extend_imm(input logic [31:0] ir);
        return {{(31 - IMM_HI){ir[IMM_HI]}}, ir[IMM_HI:0]};
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Opcode decoder: op -> ALU code, immediate-operand flag, instruction class, legality.
// mul/div/mfhi/mflo are legal only when CTRL_MULDIV_EN is defined.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [4:0] op,
    output decode_t    dec
);

    always_comb begin
        dec = '{alu_ctrl: ALU_ADD, use_imm: 1'b0, cls: CLS_ALU, legal: 1'b1};
        case (op)
            OP_LD:   begin dec.use_imm = 1'b1; dec.cls = CLS_LD; end
            OP_LDI:  dec.use_imm = 1'b1;
            OP_ST:   begin dec.use_imm = 1'b1; dec.cls = CLS_ST; end
            OP_ADD:  dec.alu_ctrl = ALU_ADD;
            OP_SUB:  dec.alu_ctrl = ALU_SUB;
            OP_AND:  dec.alu_ctrl = ALU_AND;
            OP_OR:   dec.alu_ctrl = ALU_OR;
            OP_ROR:  dec.alu_ctrl = ALU_ROR;
            OP_ROL:  dec.alu_ctrl = ALU_ROL;
            OP_SHR:  dec.alu_ctrl = ALU_SHR;
            OP_SHRA: dec.alu_ctrl = ALU_SHRA;
            OP_SHL:  dec.alu_ctrl = ALU_SHL;
            OP_ADDI: dec.use_imm = 1'b1;
            OP_ANDI: begin dec.alu_ctrl = ALU_AND; dec.use_imm = 1'b1; end
            OP_ORI:  begin dec.alu_ctrl = ALU_OR;  dec.use_imm = 1'b1; end
            OP_NEG:  dec.alu_ctrl = ALU_NEG;
            OP_NOT:  dec.alu_ctrl = ALU_NOT;
            OP_BR:   begin dec.alu_ctrl = ALU_PASSA; dec.cls = CLS_BR; end
            OP_JR:   begin dec.alu_ctrl = ALU_PASSA; dec.cls = CLS_JR; end
            OP_NOP:  dec.cls = CLS_NOP;
            OP_HALT: dec.cls = CLS_HALT;
`ifdef CTRL_MULDIV_EN
            OP_MUL:  begin dec.alu_ctrl = ALU_MUL; dec.cls = CLS_MULDIV; end
            OP_DIV:  begin dec.alu_ctrl = ALU_DIV; dec.cls = CLS_MULDIV; end
            OP_MFHI: dec.cls = CLS_MF;
            OP_MFLO: dec.cls = CLS_MF;
`endif
            // Illegal opcodes retire like a nop after flagging.
            default: begin dec.legal = 1'b0; dec.cls = CLS_NOP; end
        endcase
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle MiniSRC control unit: IR, state sequence, memory handshake, datapath strobes.
// Define CTRL_MULDIV_EN to enable mul/div/mfhi/mflo and the oRAS_en/oMUX_ASS strobes.
module datapath_sequencer
    import ctrl_pkg::*;
#(
    parameter bit START_STATE_HALT = 1'b0
)
(
    input  logic        iClk,
    input  logic        iRst,
    input  logic [31:0] iMemData,
    input  logic        iMemRdy,
    input  logic        iALU_zero,
    input  logic        iALU_neg,
    output logic        oMemRd,
    output logic        oMemWr,
    output logic        oPC_nRst,
    output logic        oPC_en,
    output logic        oPC_jmp,
    output logic        oPC_loadRA,
    output logic        oPC_loadImm,
    output logic        oRF_Write,
    output logic [3:0]  oRF_AddrA,
    output logic [3:0]  oRF_AddrB,
    output logic [3:0]  oRF_AddrC,
    output logic        oRA_en,
    output logic        oRB_en,
    output logic        oRZH_en,
    output logic        oRZL_en,
    output logic        oRAS_en,
    output logic        oRWB_en,
    output logic        oRMA_en,
    output logic        oRMD_en,
    output logic [3:0]  oALU_Ctrl,
    output logic        oMUX_B,
    output logic        oMUX_RZHS,
    output logic        oMUX_WB,
    output logic        oMUX_MA,
    output logic        oMUX_ASS,
    output logic [31:0] oImm32,
    output logic        oHalted,
    output logic        oIllegal,
    output state_t      oState
);

    // Memory handshake: oMemRd/oMemWr stay high and the FSM holds its state until
    // iMemRdy is seen in the same cycle; that cycle completes the access.

    state_t      state, next_state;
    logic [31:0] ir;
    decode_t     dec;
    logic        br_taken;

    ctrl_decode u_decode (
        .op  (ir[OP_HI:OP_LO]),
        .dec (dec)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= S_RESET;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (state == S_FETCH && iMemRdy)
                ir <= iMemData;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_RESET:  next_state = START_STATE_HALT ? S_HALT : S_FETCH;
            S_FETCH:  if (iMemRdy) next_state = S_DECODE;
            S_DECODE: begin
                case (dec.cls)
                    CLS_NOP:  next_state = S_FETCH;
                    CLS_HALT: next_state = S_HALT;
                    CLS_MF:   next_state = S_WB;
                    default:  next_state = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (dec.cls)
                    CLS_MULDIV, CLS_BR, CLS_JR: next_state = S_FETCH;
                    CLS_LD, CLS_ST:             next_state = S_MEM;
                    default:                    next_state = S_WB;
                endcase
            end
            S_MEM:    if (iMemRdy) next_state = (dec.cls == CLS_LD) ? S_WRITE : S_FETCH;
            S_WB:     next_state = S_WRITE;
            S_WRITE:  next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_RESET;
        endcase
    end

    always_comb begin
        case (ir[C2_HI:C2_LO])
            2'd0:    br_taken = iALU_zero;
            2'd1:    br_taken = !iALU_zero;
            2'd2:    br_taken = !iALU_neg && !iALU_zero;
            default: br_taken = iALU_neg;
        endcase
    end

    always_comb begin
        oMemRd      = 1'b0;
        oMemWr      = 1'b0;
        oPC_nRst    = 1'b1;
        oPC_en      = 1'b0;
        oPC_jmp     = 1'b0;
        oPC_loadRA  = 1'b0;
        oPC_loadImm = 1'b0;
        oRF_Write   = 1'b0;
        oRF_AddrA   = '0;
        oRF_AddrB   = '0;
        oRF_AddrC   = '0;
        oRA_en      = 1'b0;
        oRB_en      = 1'b0;
        oRZH_en     = 1'b0;
        oRZL_en     = 1'b0;
        oRAS_en     = 1'b0;
        oRWB_en     = 1'b0;
        oRMA_en     = 1'b0;
        oRMD_en     = 1'b0;
        oALU_Ctrl   = ALU_PASSA;
        oMUX_B      = 1'b0;
        oMUX_RZHS   = 1'b0;
        oMUX_WB     = 1'b0;
        oMUX_MA     = 1'b0;
        oMUX_ASS    = 1'b0;
        oHalted     = 1'b0;
        oIllegal    = 1'b0;
        case (state)
            S_RESET:  oPC_nRst = 1'b0;
            S_FETCH: begin
                oMemRd = 1'b1;
                oPC_en = iMemRdy;
            end
            S_DECODE: begin
                oRA_en    = 1'b1;
                oRB_en    = 1'b1;
                oIllegal  = !dec.legal;
                oRF_AddrA = ir[RB_HI:RB_LO];
                oRF_AddrB = ir[RC_HI:RC_LO];
                if (dec.cls == CLS_ST)
                    oRF_AddrB = ir[RA_HI:RA_LO];
                if (dec.cls == CLS_BR || dec.cls == CLS_JR)
                    oRF_AddrA = ir[RA_HI:RA_LO];
            end
            S_EXEC: begin
                oALU_Ctrl = dec.alu_ctrl;
                oMUX_B    = dec.use_imm;
                oRZL_en   = 1'b1;
                oRZH_en   = 1'b1;
`ifdef CTRL_MULDIV_EN
                if (dec.cls == CLS_MULDIV)
                    oRAS_en = 1'b1;
`endif
                if (dec.cls == CLS_BR && br_taken) begin
                    oPC_jmp     = 1'b1;
                    oPC_loadImm = 1'b1;
                end
                if (dec.cls == CLS_JR) begin
                    oPC_jmp    = 1'b1;
                    oPC_loadRA = 1'b1;
                end
            end
            S_MEM: begin
                oMUX_MA = 1'b1;
                if (dec.cls == CLS_LD) begin
                    oMemRd  = 1'b1;
                    oRWB_en = iMemRdy;
                end else if (dec.cls == CLS_ST) begin
                    oMemWr = 1'b1;
                end
            end
            S_WB: begin
                oRWB_en = 1'b1;
                oMUX_WB = 1'b1;
`ifdef CTRL_MULDIV_EN
                if (dec.cls == CLS_MF) begin
                    oMUX_ASS  = 1'b1;
                    oMUX_RZHS = (ir[OP_HI:OP_LO] == OP_MFHI);
                end
`endif
            end
            S_WRITE: begin
                oRF_Write = 1'b1;
                oRF_AddrC = ir[RA_HI:RA_LO];
            end
            S_HALT:   oHalted = 1'b1;
            default:  ;
        endcase
    end

    assign oImm32 = sign_extend_imm(ir);
    assign oState = state;

endmodule
